// File: rtl/sdram_pll_reset_sequencer.sv
// Filters the synchronised PLL lock and sequences SDRAM-controller then system reset release.
// Outputs are registered from the next state; lock loss drops both resets two edges after sampling.
module sdram_pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CTRL_INIT_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       sdram_reset_n,
  output logic       sys_reset_n,
  output logic       init_done,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int MAX_A = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_P = (MAX_A > CTRL_INIT_CYCLES) ? MAX_A : CTRL_INIT_CYCLES;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(CTRL_INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_locked_s;
  logic             w_relock_inc;
  logic             r_sdram_reset_n;
  logic             r_sys_reset_n;
  logic             r_init_done;
  logic [7:0]       r_relock_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Lock loss beats soft reset, which beats counter expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_relock_inc = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (r_locked_s) w_state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        if (!r_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!r_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!r_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RELEASE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!r_locked_s) begin
          w_state_nxt  = ST_WAIT_LOCK;
          w_relock_inc = 1'b1;
        end else if (soft_reset_req) begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_WAIT_LOCK;
      r_cnt           <= '0;
      r_sdram_reset_n <= 1'b0;
      r_sys_reset_n   <= 1'b0;
      r_init_done     <= 1'b0;
      r_relock_count  <= 8'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_sdram_reset_n <= (w_state_nxt == ST_RELEASE) || (w_state_nxt == ST_RUN);
      r_sys_reset_n   <= (w_state_nxt == ST_RUN);
      r_init_done     <= (w_state_nxt == ST_RUN);
      if (w_relock_inc && (r_relock_count != 8'hFF))
        r_relock_count <= r_relock_count + 8'd1;
    end
  end

  assign sdram_reset_n = r_sdram_reset_n;
  assign sys_reset_n   = r_sys_reset_n;
  assign init_done     = r_init_done;
  assign state         = r_state;
  assign relock_count  = r_relock_count;

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer with short windows (4/2/3 cycles).
module tb_sdram_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       sdram_reset_n;
  logic       sys_reset_n;
  logic       init_done;
  logic [2:0] state;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .RESET_HOLD_CYCLES (2),
    .CTRL_INIT_CYCLES  (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .sdram_reset_n (sdram_reset_n),
    .sys_reset_n   (sys_reset_n),
    .init_done     (init_done),
    .state         (state),
    .relock_count  (relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // From WAIT_LOCK with lock low: raise lock and wait until RUN (edge 11).
  task automatic go_run();
    pll_locked = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    pll_locked     = 1'b1;
    soft_reset_req = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({state, sdram_reset_n, sys_reset_n, init_done, relock_count} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d sdram=%b sys=%b done=%b cnt=%0d, expected all 0",
               state, sdram_reset_n, sys_reset_n, init_done, relock_count);
    end
    pll_locked = 1'b0;
    reset_n    = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle_no_lock: state=%0d expected 0", state);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] exp_st;
    apply_reset();
    pll_locked = 1'b1;
    tick();  // edge 0
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 8) ? 3'd2 : (e < 11) ? 3'd3 : 3'd4;
      n_checks++;
      if (state !== exp_st) begin
        n_fail++;
        $display("FAIL powerup_state e%0d: state=%0d expected %0d", e, state, exp_st);
      end
      n_checks++;
      if (sdram_reset_n !== (e >= 8)) begin
        n_fail++;
        $display("FAIL powerup_sdram e%0d: sdram_reset_n=%b expected %b", e, sdram_reset_n, (e >= 8));
      end
      n_checks++;
      if ({sys_reset_n, init_done} !== {2{e >= 11}}) begin
        n_fail++;
        $display("FAIL powerup_sys e%0d: sys=%b done=%b expected %b", e, sys_reset_n, init_done, (e >= 11));
      end
    end
    n_checks++;
    if (relock_count !== 8'd0) begin
      n_fail++;
      $display("FAIL powerup_relock: relock_count=%0d expected 0", relock_count);
    end
  endtask

  task automatic test_lock_bounce();
    apply_reset();
    pll_locked = 1'b1;
    tick();  // edge 0
    tick();
    tick();  // edge 2
    pll_locked = 1'b0;
    for (int e = 3; e <= 6; e++) begin
      tick();
      n_checks++;
      if (state !== ((e < 5) ? 3'd1 : 3'd0)) begin
        n_fail++;
        $display("FAIL bounce_state e%0d: state=%0d expected %0d", e, state, (e < 5) ? 1 : 0);
      end
      n_checks++;
      if ({sdram_reset_n, sys_reset_n} !== 2'b00) begin
        n_fail++;
        $display("FAIL bounce_resets e%0d: sdram=%b sys=%b expected 0 0", e, sdram_reset_n, sys_reset_n);
      end
    end
    pll_locked = 1'b1;
    tick();  // re-lock edge 0
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_checks++;
      if (state !== ((e < 2) ? 3'd0 : (e < 6) ? 3'd1 : 3'd2)) begin
        n_fail++;
        $display("FAIL relock_window e%0d: state=%0d", e, state);
      end
    end
  endtask

  task automatic test_lock_loss();
    apply_reset();
    go_run();
    pll_locked = 1'b0;
    tick();  // edge j
    tick();  // edge j+1
    n_checks++;
    if (state !== 3'd4 || sys_reset_n !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_j1: state=%0d sys=%b expected 4 1", state, sys_reset_n);
    end
    tick();  // edge j+2
    n_checks++;
    if ({state, sdram_reset_n, sys_reset_n, init_done} !== 6'd0) begin
      n_fail++;
      $display("FAIL loss_j2: state=%0d sdram=%b sys=%b done=%b expected 0", state, sdram_reset_n, sys_reset_n, init_done);
    end
    n_checks++;
    if (relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_count: relock_count=%0d expected 1", relock_count);
    end
    for (int i = 2; i <= 300; i++) begin
      go_run();
      n_checks++;
      if (state !== 3'd4) begin
        n_fail++;
        $display("FAIL loss_rerun %0d: state=%0d expected 4", i, state);
      end
      pll_locked = 1'b0;
      tick();
      tick();
      tick();
      if (i == 254 || i == 255 || i == 256) begin
        n_checks++;
        if (relock_count !== ((i < 255) ? 8'(i) : 8'd255)) begin
          n_fail++;
          $display("FAIL loss_sat %0d: relock_count=%0d", i, relock_count);
        end
      end
    end
    n_checks++;
    if (relock_count !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_300: relock_count=%0d expected 255", relock_count);
    end
  endtask

  task automatic test_soft_reset();
    logic [2:0] exp_st;
    apply_reset();
    go_run();
    soft_reset_req = 1'b1;
    tick();  // request sampled here
    soft_reset_req = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      exp_st = (e < 2) ? 3'd2 : (e < 5) ? 3'd3 : 3'd4;
      n_checks++;
      if (state !== exp_st || sdram_reset_n !== (e >= 2) || sys_reset_n !== (e >= 5) || init_done !== (e >= 5)) begin
        n_fail++;
        $display("FAIL soft_run +%0d: state=%0d sdram=%b sys=%b done=%b expected state %0d", e, state, sdram_reset_n, sys_reset_n, init_done, exp_st);
      end
      if (e < 5) tick();
    end
    // Same pulse while STABLE must not shorten the window.
    apply_reset();
    pll_locked = 1'b1;
    tick();  // edge 0
    tick();
    tick();  // edge 2
    soft_reset_req = 1'b1;
    tick();  // edge 3
    soft_reset_req = 1'b0;
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL soft_stable_e3: state=%0d expected 1", state);
    end
    tick();
    tick();  // edge 5
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL soft_stable_e5: state=%0d expected 1", state);
    end
    tick();  // edge 6
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL soft_stable_e6: state=%0d expected 2", state);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    go_run();
    pll_locked = 1'b0;
    tick();  // edge j
    tick();  // edge j+1: locked_s now low
    soft_reset_req = 1'b1;
    tick();  // edge j+2
    soft_reset_req = 1'b0;
    n_checks++;
    if (state !== 3'd0 || sdram_reset_n !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_state: state=%0d sdram=%b expected 0 0", state, sdram_reset_n);
    end
    n_checks++;
    if (relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL simul_count: relock_count=%0d expected 1", relock_count);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    go_run();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) tick();  // edge 9 of re-lock
    n_checks++;
    if (state !== 3'd3 || sdram_reset_n !== 1'b1 || relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL async_pre: state=%0d sdram=%b cnt=%0d expected 3 1 1", state, sdram_reset_n, relock_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({state, sdram_reset_n, sys_reset_n, init_done, relock_count} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d sdram=%b sys=%b done=%b cnt=%0d expected all 0",
               state, sdram_reset_n, sys_reset_n, init_done, relock_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_bounce();
    test_lock_loss();
    test_soft_reset();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
